// File: rtl/trace_pkg.sv
// Shared encodings and record-width helper for the trace buffer.
// Record layout grows by one DATA_W field when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] FLT_ALL   = 2'b00;
  localparam logic [1:0] FLT_MEM   = 2'b01;
  localparam logic [1:0] FLT_WRITE = 2'b10;
  localparam logic [1:0] FLT_PAUSE = 2'b11;

`ifdef TRACE_TIMESTAMP_EN
  localparam int REC_FIELDS = 5;
`else
  localparam int REC_FIELDS = 4;
`endif

  // Fields are packed MSB-first as {[time,] pc, instr, alu, mem, write, read}.
  function automatic int rec_w(input int data_w);
    return REC_FIELDS * data_w + 2;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Record storage: synchronous write port, asynchronous read port.
// Contents are never reset; validity is tracked by the owner's count.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 130
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Circular trace capture with trigger/post-trigger window and handshake readout.
// Optional TRACE_TIMESTAMP_EN adds a free-running cycle stamp per record and rd_time.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               filter_mode,
  input  logic                     trigger,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic [DATA_W-1:0]        instr_in,
  input  logic [DATA_W-1:0]        alu_in,
  input  logic [DATA_W-1:0]        mem_in,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_alu,
  output logic [DATA_W-1:0]        rd_mem,
  output logic [1:0]               rd_flags,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [DATA_W-1:0]        rd_time
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = rec_w(DATA_W);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] POST_C  = CW'(POST_TRIG);

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   post_cnt_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic            overflow_reg;

  logic            qualify;
  logic            wr_en;
  logic [DATA_W-1:0] mem_field;
  logic [RW-1:0]   wdata;
  logic [RW-1:0]   rdata;

  always_comb begin
    qualify = 1'b0;
    case (filter_mode)
      FLT_ALL:   qualify = 1'b1;
      FLT_MEM:   qualify = mem_read | mem_write;
      FLT_WRITE: qualify = mem_write;
      default:   qualify = 1'b0;
    endcase
  end

  assign wr_en     = enable && qualify && (state_reg == ST_ARMED || state_reg == ST_POST);
  assign mem_field = mem_read ? mem_in : '0;

`ifdef TRACE_TIMESTAMP_EN
  logic [DATA_W-1:0] time_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) time_reg <= '0;
    else       time_reg <= time_reg + 1'b1;
  end

  assign wdata   = {time_reg, pc_in, instr_in, alu_in, mem_field, mem_write, mem_read};
  assign rd_time = rdata[5*DATA_W+1 : 4*DATA_W+2];
`else
  assign wdata = {pc_in, instr_in, alu_in, mem_field, mem_write, mem_read};
`endif

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (wdata),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      post_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg    <= ST_ARMED;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
          end
        end
        ST_ARMED, ST_POST: begin
          if (!enable) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            post_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
          end else begin
            if (qualify) begin
              wr_ptr_reg <= wr_ptr_reg + 1'b1;
              // When full, the new record lands on the oldest slot, so the read side moves with it.
              if (count_reg == DEPTH_C) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                overflow_reg <= 1'b1;
              end else begin
                count_reg <= count_reg + 1'b1;
              end
            end
            if (state_reg == ST_ARMED && trigger) begin
              post_cnt_reg <= POST_C;
              state_reg    <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
            end else if (state_reg == ST_POST && qualify) begin
              post_cnt_reg <= post_cnt_reg - 1'b1;
              if (post_cnt_reg == CW'(1)) state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (count_reg == '0) begin
            state_reg <= ST_IDLE;
          end else if (rd_ready) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg  <= count_reg - 1'b1;
          end
        end
      endcase
    end
  end

  assign state    = state_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign rd_valid = (state_reg == ST_DONE) && (count_reg != '0);
  assign rd_pc    = rdata[4*DATA_W+1 : 3*DATA_W+2];
  assign rd_instr = rdata[3*DATA_W+1 : 2*DATA_W+2];
  assign rd_alu   = rdata[2*DATA_W+1 : DATA_W+2];
  assign rd_mem   = rdata[DATA_W+1 : 2];
  assign rd_flags = rdata[1:0];

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: two instances (POST_TRIG=2 and POST_TRIG=0).
// Build with TRACE_TIMESTAMP_EN to also exercise rd_time ordering.
module tb_trace_buffer;

  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [1:0]    flags;
  } rec_t;

  logic clock = 1'b0;
  logic reset;
  logic en_a, en_b, rdy_a, rdy_b;
  logic [1:0] filter_mode;
  logic trigger, mem_read, mem_write;
  logic [DW-1:0] pc_in, instr_in, alu_in, mem_in;

  logic rd_valid_a, rd_valid_b, overflow_a, overflow_b;
  logic [DW-1:0] rd_pc_a, rd_instr_a, rd_alu_a, rd_mem_a;
  logic [DW-1:0] rd_pc_b, rd_instr_b, rd_alu_b, rd_mem_b;
  logic [1:0] rd_flags_a, rd_flags_b, state_a, state_b;
  logic [6:0] count_a, count_b;
`ifdef TRACE_TIMESTAMP_EN
  logic [DW-1:0] rd_time_a, rd_time_b;
`endif

  rec_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  trace_buffer #(.DATA_W(DW), .DEPTH(64), .POST_TRIG(2)) dut_a (
    .clock(clock), .reset(reset), .enable(en_a), .filter_mode(filter_mode),
    .trigger(trigger), .pc_in(pc_in), .instr_in(instr_in), .alu_in(alu_in),
    .mem_in(mem_in), .mem_read(mem_read), .mem_write(mem_write),
    .rd_valid(rd_valid_a), .rd_ready(rdy_a), .rd_pc(rd_pc_a), .rd_instr(rd_instr_a),
    .rd_alu(rd_alu_a), .rd_mem(rd_mem_a), .rd_flags(rd_flags_a), .state(state_a),
    .count(count_a), .overflow(overflow_a)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_time(rd_time_a)
`endif
  );

  trace_buffer #(.DATA_W(DW), .DEPTH(64), .POST_TRIG(0)) dut_b (
    .clock(clock), .reset(reset), .enable(en_b), .filter_mode(filter_mode),
    .trigger(trigger), .pc_in(pc_in), .instr_in(instr_in), .alu_in(alu_in),
    .mem_in(mem_in), .mem_read(mem_read), .mem_write(mem_write),
    .rd_valid(rd_valid_b), .rd_ready(rdy_b), .rd_pc(rd_pc_b), .rd_instr(rd_instr_b),
    .rd_alu(rd_alu_b), .rd_mem(rd_mem_b), .rd_flags(rd_flags_b), .state(state_b),
    .count(count_b), .overflow(overflow_b)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_time(rd_time_b)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] pc, input logic [DW-1:0] instr,
                       input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                       input logic mr, input logic mw, input logic trig);
    pc_in = pc; instr_in = instr; alu_in = alu; mem_in = mem;
    mem_read = mr; mem_write = mw; trigger = trig;
  endtask

  // Expected record as the buffer should store it; oldest dropped beyond limit.
  function automatic void push_exp(input logic [DW-1:0] pc, input logic [DW-1:0] instr,
                                   input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                                   input logic mr, input logic mw, input int limit);
    rec_t r;
    r.pc = pc; r.instr = instr; r.alu = alu;
    r.mem = mr ? mem : '0;
    r.flags = {mw, mr};
    if (exp_q.size() >= limit) void'(exp_q.pop_front());
    exp_q.push_back(r);
  endfunction

  task automatic test_reset();
    reset = 1'b1; en_a = 0; en_b = 0; rdy_a = 0; rdy_b = 0; filter_mode = 2'b00;
    drive('0, '0, '0, '0, 0, 0, 0);
    repeat (2) tick();
    checks++;
    if (state_a !== 2'b00 || count_a !== 7'd0 || rd_valid_a !== 1'b0 || overflow_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a state=%0d count=%0d valid=%0b ovf=%0b want 0/0/0/0", state_a, count_a, rd_valid_a, overflow_a);
    end
    checks++;
    if (state_b !== 2'b00 || count_b !== 7'd0 || rd_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b state=%0d count=%0d valid=%0b want 0/0/0", state_b, count_b, rd_valid_b);
    end
    reset = 1'b0;
    tick();
    $display("reset done state_a=%0d state_b=%0d", state_a, state_b);
  endtask

  task automatic test_capture_readout();
    rec_t e, obs, held;
    logic [DW-1:0] prev_t;
    exp_q.delete();
    filter_mode = 2'b00; en_a = 1'b1;
    tick();
    checks++;
    if (state_a !== 2'b01 || count_a !== 7'd0) begin
      errors++;
      $display("FAIL arm state=%0d count=%0d want 1/0", state_a, count_a);
    end
    for (int i = 0; i < 12; i++) begin
      drive(DW'(i * 4), DW'(32'h1000 + i), DW'(i * 3), 32'hDEADBEEF, i[0], 1'b0, i == 9);
      push_exp(DW'(i * 4), DW'(32'h1000 + i), DW'(i * 3), 32'hDEADBEEF, i[0], 1'b0, 64);
      tick();
      if (i >= 9) begin
        checks++;
        if (state_a !== ((i == 11) ? 2'b11 : 2'b10)) begin
          errors++;
          $display("FAIL post_window cyc=%0d state=%0d want %0d", i, state_a, (i == 11) ? 3 : 2);
        end
      end
    end
    en_a = 1'b0; trigger = 1'b0;
    checks++;
    if (count_a !== 7'd12 || rd_valid_a !== 1'b1 || rd_pc_a !== 32'h0) begin
      errors++;
      $display("FAIL done_a count=%0d valid=%0b pc=%h want 12/1/00000000", count_a, rd_valid_a, rd_pc_a);
    end
    checks++;
    if (rd_mem_a !== 32'h0) begin
      errors++;
      $display("FAIL mem_no_read got %h want 00000000", rd_mem_a);
    end
    rdy_a = 1'b0;
    held = {rd_pc_a, rd_instr_a, rd_alu_a, rd_mem_a, rd_flags_a};
    for (int s = 0; s < 5; s++) begin
      tick();
      obs = {rd_pc_a, rd_instr_a, rd_alu_a, rd_mem_a, rd_flags_a};
      checks++;
      if (obs !== held || count_a !== 7'd12 || rd_valid_a !== 1'b1) begin
        errors++;
        $display("FAIL stall cyc=%0d rec=%h count=%0d want rec=%h count=12", s, obs, count_a, held);
      end
    end
    rdy_a = 1'b1;
    prev_t = '0;
    for (int k = 0; k < 12; k++) begin
      obs = {rd_pc_a, rd_instr_a, rd_alu_a, rd_mem_a, rd_flags_a};
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++;
      if (obs !== e || rd_valid_a !== 1'b1) begin
        errors++;
        $display("FAIL readout_a idx=%0d got %h valid=%0b want %h", k, obs, rd_valid_a, e);
      end
`ifdef TRACE_TIMESTAMP_EN
      if (k > 0) begin
        checks++;
        if (!(rd_time_a > prev_t)) begin
          errors++;
          $display("FAIL time_order idx=%0d got %0d want > %0d", k, rd_time_a, prev_t);
        end
      end
      prev_t = rd_time_a;
`endif
      tick();
      checks++;
      if (count_a !== 7'(11 - k)) begin
        errors++;
        $display("FAIL count_dec idx=%0d got %0d want %0d", k, count_a, 11 - k);
      end
    end
    rdy_a = 1'b0;
    checks++;
    if (state_a !== 2'b11 || rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL drained state=%0d valid=%0b want 3/0", state_a, rd_valid_a);
    end
    tick();
    checks++;
    if (state_a !== 2'b00) begin
      errors++;
      $display("FAIL back_idle got %0d want 0", state_a);
    end
    $display("capture/readout done, %0d records left in model", exp_q.size());
  endtask

  task automatic test_overflow();
    rec_t e, obs;
    exp_q.delete();
    filter_mode = 2'b00; en_b = 1'b1;
    tick();
    for (int i = 0; i <= 70; i++) begin
      drive(DW'(i), ~DW'(i), DW'(i * 7), DW'(32'h5000 + i), 1'b1, i[0], i == 70);
      push_exp(DW'(i), ~DW'(i), DW'(i * 7), DW'(32'h5000 + i), 1'b1, i[0], 64);
      tick();
    end
    en_b = 1'b0; trigger = 1'b0;
    checks++;
    if (state_b !== 2'b11 || count_b !== 7'd64 || overflow_b !== 1'b1) begin
      errors++;
      $display("FAIL overflow state=%0d count=%0d ovf=%0b want 3/64/1", state_b, count_b, overflow_b);
    end
    checks++;
    if (rd_pc_b !== 32'd7) begin
      errors++;
      $display("FAIL oldest_after_wrap got %h want 00000007", rd_pc_b);
    end
    rdy_b = 1'b1;
    for (int k = 0; k < 64; k++) begin
      obs = {rd_pc_b, rd_instr_b, rd_alu_b, rd_mem_b, rd_flags_b};
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++;
      if (obs !== e || rd_valid_b !== 1'b1) begin
        errors++;
        $display("FAIL readout_b idx=%0d got %h valid=%0b want %h", k, obs, rd_valid_b, e);
      end
      tick();
    end
    rdy_b = 1'b0;
    tick();
    checks++;
    if (state_b !== 2'b00 || count_b !== 7'd0) begin
      errors++;
      $display("FAIL overflow_idle state=%0d count=%0d want 0/0", state_b, count_b);
    end
    $display("overflow run done");
  endtask

  task automatic test_filter_write();
    int kinds[9] = '{0, 1, 2, 0, 1, 2, 1, 0, 1};
    rec_t e, obs;
    logic [DW-1:0] alu;
    exp_q.delete();
    filter_mode = 2'b10; en_a = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      alu = (i == 1) ? 32'h10 : DW'(32'h100 + i);
      drive(DW'(32'h400 + 4 * i), DW'(kinds[i]), alu, 32'hDEADBEEF,
            kinds[i] == 0, kinds[i] == 1, i == 4);
      if (kinds[i] == 1) push_exp(DW'(32'h400 + 4 * i), DW'(kinds[i]), alu, 32'hDEADBEEF, 1'b0, 1'b1, 64);
      tick();
    end
    en_a = 1'b0; trigger = 1'b0;
    checks++;
    if (state_a !== 2'b11 || count_a !== 7'd4 || rd_alu_a !== 32'h10) begin
      errors++;
      $display("FAIL filter_wr state=%0d count=%0d alu=%h want 3/4/00000010", state_a, count_a, rd_alu_a);
    end
    rdy_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      obs = {rd_pc_a, rd_instr_a, rd_alu_a, rd_mem_a, rd_flags_a};
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++;
      if (obs !== e || rd_flags_a !== 2'b10) begin
        errors++;
        $display("FAIL filter_rec idx=%0d got %h flags=%b want %h flags=10", k, obs, rd_flags_a, e);
      end
      tick();
    end
    rdy_a = 1'b0;
    tick();
    $display("filter writes-only done state_a=%0d", state_a);
  endtask

  task automatic test_abort_pause();
    filter_mode = 2'b11; en_a = 1'b1;
    tick();
    repeat (3) begin
      drive(32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (state_a !== 2'b01 || count_a !== 7'd0) begin
      errors++;
      $display("FAIL pause state=%0d count=%0d want 1/0", state_a, count_a);
    end
    filter_mode = 2'b00;
    repeat (3) tick();
    checks++;
    if (count_a !== 7'd3) begin
      errors++;
      $display("FAIL resume count=%0d want 3", count_a);
    end
    en_a = 1'b0;
    tick();
    checks++;
    if (state_a !== 2'b00 || count_a !== 7'd0) begin
      errors++;
      $display("FAIL abort state=%0d count=%0d want 0/0", state_a, count_a);
    end
    $display("pause/abort done");
  endtask

  task automatic test_reset_mid();
    filter_mode = 2'b00; en_a = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(DW'(i), '0, '0, '0, 1'b0, 1'b0, i == 3);
      tick();
    end
    trigger = 1'b0;
    checks++;
    if (state_a !== 2'b10 || count_a !== 7'd5) begin
      errors++;
      $display("FAIL pre_reset state=%0d count=%0d want 2/5", state_a, count_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state_a !== 2'b00 || count_a !== 7'd0 || rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset state=%0d count=%0d valid=%0b want 0/0/0", state_a, count_a, rd_valid_a);
    end
    en_a = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (state_a !== 2'b00 || count_a !== 7'd0) begin
      errors++;
      $display("FAIL post_reset state=%0d count=%0d want 0/0", state_a, count_a);
    end
    $display("mid-capture reset done");
  endtask

  initial begin
    test_reset();
    test_capture_readout();
    test_overflow();
    test_filter_write();
    test_abort_pause();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
